dtw_stream_engine: RTL and testbench
====================================

# dtw_stream_engine

Parametrised successor to the fixed-size DTW datapath. A streaming subsequence-DTW engine: it holds a QLEN-sample query in an internal buffer and runs a QLEN-PE systolic array over a ready/valid reference stream that may contain bubbles. It emits a per-column end score stream, and tracks the minimum score, its reference position, and a threshold hit count. It sits between the squiggle/reference fetch logic and the result-reporting FSM, and adds query retention across runs and an explicit start/done sequence.

## Interface
- WIDTH, 18: sample and score width. All-ones means +infinity.
- QLEN, 250: query length, which is also the PE count. Must be ≥2.
- POSW, 32: width of the reference position counter and the hit counter.
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- start  in  1  pulse; accepted only in IDLE.
- keep_query  in  1  sampled with start; 1 skips LOAD and reuses the stored query.
- threshold  in  WIDTH  hit threshold. Sampled at start and held for the run.
- q_valid, q_ready  in/out  1  query load handshake.
- q_data  in  WIDTH  query sample.
- r_valid, r_ready  in/out  1  reference stream handshake.
- r_data  in  WIDTH  reference sample.
- r_last  in  1  marks the final reference sample.
- s_valid  out  1  one per accepted reference sample; no backpressure.
- s_score  out  WIDTH  end score D[QLEN][j] for the column.
- s_pos  out  POSW  0-based column index j.
- min_score  out  WIDTH  best end score so far.
- min_pos  out  POSW  column of min_score.
- hit_count  out  POSW  number of columns with score ≤ threshold.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run.

## Operation
- Recurrence:
  - D[i][j] = |q_i − r_j| + min(D[i−1][j], D[i][j−1], D[i−1][j−1]).
  - D[0][j] = 0 (free start); D[i][−1] = all-ones.
  - Absolute difference is unsigned.
  - Every add saturates at all-ones; all-ones + anything = all-ones.
- State machine: IDLE, LOAD, RUN, DRAIN, DONE.
  - IDLE: q_ready=0, r_ready=0. On start, latch threshold and clear min_score to all-ones, min_pos to 0, hit_count to 0, and the column counter to 0.
    - start with keep_query=0 → LOAD. Query write index resets to 0.
    - start with keep_query=1 → RUN.
    - Start clears every PE's D[i][j−1] and D[i−1][j−1] registers to all-ones.
  - LOAD: q_ready=1. Each accepted beat writes q[index]. After the QLEN-th beat → RUN. Extra q beats are never accepted.
  - RUN: r_ready=1. Each accepted beat enters PE1 with a valid tag. An accepted beat with r_last=1 → DRAIN; r_ready drops in the same edge.
  - DRAIN: r_ready=0. Remain until the last column's min/hit update has been applied, then → DONE.
  - DONE: done=1 for exactly this cycle, then → IDLE. Results hold until the next accepted start.
- Array and bubbles:
  - Each PE stage carries a valid bit.
  - A PE updates its left-neighbour register (D[i][j−1]) and its diagonal register only on valid input.
  - Bubbles therefore propagate without corrupting the recurrence, and the score sequence is independent of r_valid gaps.
- Column counter:
  - Increments per accepted reference beat.
  - Wraps modulo 2^POSW.
  - s_pos carries the index assigned at acceptance.
- Min tracking: update when s_score < min_score (strict). Ties keep the earliest column.
- Hit counter: increment when s_score ≤ threshold. Saturates at all-ones.
- Ignored inputs:
  - start outside IDLE is ignored.
  - keep_query=1 after reset, before any LOAD, uses the all-zero query.

## Timing
- Reference beat accepted at edge t:
  - PE k registers column j at edge t+k.
  - s_valid/s_score/s_pos are registered at edge t+QLEN, i.e. visible for one cycle, QLEN cycles after acceptance.
- min_score/min_pos/hit_count update at edge t+QLEN+1.
- done is high in the cycle after the last column's update.
- Throughput is one column per cycle with r_valid held high.
- Reset (asynchronous, any state including mid-run):
  - State → IDLE.
  - All outputs 0, except min_score = all-ones.
  - Query buffer and PE registers cleared: query to 0, D registers to all-ones.
  - Valid tags cleared; no s_valid appears after reset from in-flight columns.
- An r_last on the same edge as the first RUN beat is legal; that one column completes normally.

## Test plan
- Basic match: QLEN=4, WIDTH=8, query [1,2,3,4], threshold 0, reference [9,1,2,3,4,9] streamed back-to-back → min_score=0, min_pos=4, hit_count=1. done pulses 4+2 cycles after the r_last acceptance.
- Bubbles: same stimulus with r_valid toggled every other cycle → s_score sequence identical to the back-to-back run; s_pos values 0..5.
- Ties and threshold: query [1,2,3,4], reference [1,2,3,4,1,2,3,4], threshold 0 → min_pos=3 (earliest tie), hit_count=2.
- Saturation: query [0,0,0,0], reference [255] → s_score=255, min_score stays 255 (no strict improvement), min_pos=0, hit_count=0 with threshold 254.
- keep_query: after the basic run, start with keep_query=1 → no q_ready assertion; reference [1,2,3,4] → min_score=0, min_pos=3.
- Reset mid-run: assert rst_n low while RUN with columns in flight → busy=0, s_valid=0, min_score=255 immediately. No s_valid after release until a new start.

Source files
------------

// File: rtl/dtw_stream_engine.sv
// Streaming subsequence-DTW engine: a QLEN-PE systolic array scores a reference
// stream against a retained query, tracking the best end score and threshold hits.
module dtw_stream_engine #(
  parameter int WIDTH = 18,
  parameter int QLEN  = 250,
  parameter int POSW  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             keep_query,
  input  logic [WIDTH-1:0] threshold,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [WIDTH-1:0] q_data,
  input  logic             r_valid,
  output logic             r_ready,
  input  logic [WIDTH-1:0] r_data,
  input  logic             r_last,
  output logic             s_valid,
  output logic [WIDTH-1:0] s_score,
  output logic [POSW-1:0]  s_pos,
  output logic [WIDTH-1:0] min_score,
  output logic [POSW-1:0]  min_pos,
  output logic [POSW-1:0]  hit_count,
  output logic             busy,
  output logic             done
);
  localparam logic [WIDTH-1:0] INF = '1;
  localparam int QW = $clog2(QLEN);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic [WIDTH-1:0] f_absdiff(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // All-ones is +infinity and absorbs any addend; overflow clamps to it.
  function automatic logic [WIDTH-1:0] f_sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (a == INF || b == INF || sum[WIDTH]) return INF;
    return sum[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] f_min3(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_thr;
  logic [QW-1:0]    r_qidx;
  logic [POSW-1:0]  r_opos;
  logic [WIDTH-1:0] r_q     [QLEN];
  logic [WIDTH-1:0] r_ref_p [QLEN];
  logic             r_vld_p [QLEN+1];
  logic [WIDTH-1:0] r_up_p  [1:QLEN];
  logic [WIDTH-1:0] r_left  [1:QLEN];
  logic [WIDTH-1:0] r_diag  [1:QLEN];
  logic             w_clr;
  logic             w_any_vld;

  assign w_clr   = (r_state == S_IDLE) && start;
  assign s_valid = r_vld_p[QLEN];
  assign s_score = r_up_p[QLEN];

  always_comb begin
    w_any_vld = 1'b0;
    for (int i = 0; i <= QLEN; i++) w_any_vld = w_any_vld | r_vld_p[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QLEN; i++) r_q[i] <= '0;
    end else if (r_state == S_LOAD && q_valid) begin
      r_q[r_qidx] <= q_data;
    end
  end

  // ---- PE stages: stage k holds D[k][j] for the column that entered k edges ago
  for (genvar k = 1; k <= QLEN; k++) begin : g_pe
    logic [WIDTH-1:0] w_up_in;
    logic [WIDTH-1:0] w_d;
    if (k == 1) begin : g_top
      assign w_up_in = '0;
    end else begin : g_mid
      assign w_up_in = r_up_p[k-1];
    end
    assign w_d = f_sat_add(f_absdiff(r_q[k-1], r_ref_p[k-1]),
                           f_min3(w_up_in, r_left[k], r_diag[k]));

    // Left/diagonal history advances only on real columns so bubbles are inert.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld_p[k] <= 1'b0;
        r_up_p[k]  <= '0;
        r_left[k]  <= INF;
        r_diag[k]  <= INF;
      end else begin
        r_vld_p[k] <= r_vld_p[k-1];
        if (w_clr) begin
          r_left[k] <= INF;
          r_diag[k] <= INF;
        end else if (r_vld_p[k-1]) begin
          r_up_p[k] <= w_d;
          r_left[k] <= w_d;
          r_diag[k] <= w_up_in;
        end
      end
    end

    if (k < QLEN) begin : g_ref
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_ref_p[k] <= '0;
        else if (r_vld_p[k-1])   r_ref_p[k] <= r_ref_p[k-1];
      end
    end
  end

  // ---- Control, stage-0 entry, output position and result tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_thr      <= '0;
      r_qidx     <= '0;
      r_opos     <= '0;
      r_vld_p[0] <= 1'b0;
      r_ref_p[0] <= '0;
      s_pos      <= '0;
      min_score  <= INF;
      min_pos    <= '0;
      hit_count  <= '0;
      q_ready    <= 1'b0;
      r_ready    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_vld_p[0] <= r_valid && r_ready;
      r_ref_p[0] <= r_data;
      if (r_vld_p[QLEN-1]) begin
        s_pos  <= r_opos;
        r_opos <= r_opos + 1'b1;
      end
      if (s_valid) begin
        if (s_score < min_score) begin
          min_score <= s_score;
          min_pos   <= s_pos;
        end
        if (s_score <= r_thr && hit_count != '1) hit_count <= hit_count + 1'b1;
      end
      case (r_state)
        S_IDLE: if (start) begin
          r_thr     <= threshold;
          min_score <= INF;
          min_pos   <= '0;
          hit_count <= '0;
          r_opos    <= '0;
          busy      <= 1'b1;
          if (keep_query) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end else begin
            r_state <= S_LOAD;
            r_qidx  <= '0;
            q_ready <= 1'b1;
          end
        end
        S_LOAD: if (q_valid) begin
          r_qidx <= r_qidx + 1'b1;
          if (r_qidx == QW'(QLEN-1)) begin
            q_ready <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: if (r_valid && r_last) begin
          r_ready <= 1'b0;
          r_state <= S_DRAIN;
        end
        S_DRAIN: if (!w_any_vld) begin
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_stream_engine.sv
// Scoreboard bench for dtw_stream_engine (QLEN=4, WIDTH=8): directed runs with
// hand-computed column scores checked by an independent output monitor.
module tb_dtw_stream_engine;
  localparam int W  = 8;
  localparam int QL = 4;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, keep_query;
  logic [W-1:0]  threshold;
  logic          q_valid, q_ready;
  logic [W-1:0]  q_data;
  logic          r_valid, r_ready;
  logic [W-1:0]  r_data;
  logic          r_last;
  logic          s_valid;
  logic [W-1:0]  s_score;
  logic [PW-1:0] s_pos;
  logic [W-1:0]  min_score;
  logic [PW-1:0] min_pos;
  logic [PW-1:0] hit_count;
  logic          busy, done;

  always #5 clk = ~clk;

  dtw_stream_engine #(.WIDTH(W), .QLEN(QL), .POSW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .keep_query(keep_query),
    .threshold(threshold), .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
    .s_valid(s_valid), .s_score(s_score), .s_pos(s_pos), .min_score(min_score),
    .min_pos(min_pos), .hit_count(hit_count), .busy(busy), .done(done)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int sb_score[$];
  int sb_pos[$];
  int sv_seen = 0;
  bit q_ready_seen = 1'b0;
  int qv[];
  int ref_v[];
  int exp_v[];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Output monitor: every presented column must match the head of the scoreboard.
  always @(negedge clk) begin
    if (q_ready) q_ready_seen = 1'b1;
    if (rst_n && s_valid) begin
      sv_seen++;
      if (sb_score.size() == 0) begin
        check("unexpected_s_valid", 1, 0);
      end else begin
        int es, ep;
        es = sb_score.pop_front();
        ep = sb_pos.pop_front();
        check("s_score", s_score, es);
        check("s_pos", s_pos, ep);
      end
    end
  end

  task automatic do_start(input bit keep, input int thr);
    start = 1'b1; keep_query = keep; threshold = W'(thr);
    @(posedge clk); #1;
    start = 1'b0; keep_query = 1'b0;
  endtask

  task automatic load_query();
    int i, guard;
    bit acc;
    i = 0; guard = 0;
    while (i < QL && guard < 50) begin
      q_valid = 1'b1; q_data = W'(qv[i]);
      acc = q_valid && q_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    q_valid = 1'b0;
    check("load_accept", i, QL);
    check("q_ready_after_load", q_ready, 0);
  endtask

  task automatic stream(input bit bubble, input bit use_last);
    int i, guard;
    bit acc;
    i = 0; guard = 0;
    while (i < ref_v.size() && guard < 100) begin
      r_valid = bubble ? ((guard % 2) == 0) : 1'b1;
      r_data  = W'(ref_v[i]);
      r_last  = use_last && (i == ref_v.size() - 1);
      acc = r_valid && r_ready;
      @(posedge clk); #1;
      if (acc) begin
        sb_score.push_back(exp_v[i]);
        sb_pos.push_back(i);
        i++;
      end
      guard++;
    end
    r_valid = 1'b0; r_last = 1'b0;
    check("stream_accept", i, ref_v.size());
  endtask

  task automatic finish_run(input string name, input int e_min, input int e_pos, input int e_hit);
    int c;
    c = 0;
    while (!done && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    check({name, "_done_latency"}, c, QL + 2);
    @(posedge clk); #1;
    check({name, "_done_pulse"}, done, 0);
    check({name, "_busy_idle"}, busy, 0);
    check({name, "_min_score"}, min_score, e_min);
    check({name, "_min_pos"}, min_pos, e_pos);
    check({name, "_hit_count"}, hit_count, e_hit);
    check({name, "_sb_empty"}, sb_score.size(), 0);
  endtask

  initial begin
    int sv_before;
    rst_n = 1'b0; start = 1'b0; keep_query = 1'b0; threshold = '0;
    q_valid = 1'b0; q_data = '0; r_valid = 1'b0; r_data = '0; r_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s_valid", s_valid, 0);
    check("rst_min_score", min_score, 255);
    check("rst_min_pos", min_pos, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_q_ready", q_ready, 0);
    check("rst_r_ready", r_ready, 0);

    // Basic match
    do_start(1'b0, 0);
    check("load_busy", busy, 1);
    qv = '{1, 2, 3, 4};
    load_query();
    ref_v = '{9, 1, 2, 3, 4, 9};
    exp_v = '{26, 6, 3, 1, 0, 5};
    stream(1'b0, 1'b1);
    finish_run("basic", 0, 4, 1);

    // Same columns with bubbles between beats
    do_start(1'b1, 0);
    stream(1'b1, 1'b1);
    finish_run("bubble", 0, 4, 1);

    // Ties keep the earliest column; both perfect matches count as hits
    do_start(1'b1, 0);
    ref_v = '{1, 2, 3, 4, 1, 2, 3, 4};
    exp_v = '{6, 3, 1, 0, 3, 3, 1, 0};
    stream(1'b0, 1'b1);
    finish_run("ties", 0, 3, 2);

    // Reused query, no load phase
    q_ready_seen = 1'b0;
    do_start(1'b1, 0);
    ref_v = '{1, 2, 3, 4};
    exp_v = '{6, 3, 1, 0};
    stream(1'b0, 1'b1);
    finish_run("keepq", 0, 3, 1);
    check("keepq_no_q_ready", q_ready_seen, 0);

    // Saturation: single column, r_last on the first beat
    do_start(1'b0, 254);
    qv = '{0, 0, 0, 0};
    load_query();
    ref_v = '{255};
    exp_v = '{255};
    stream(1'b0, 1'b1);
    finish_run("sat", 255, 0, 0);

    // Asynchronous reset with columns in flight
    do_start(1'b1, 0);
    ref_v = '{5, 6, 7};
    exp_v = '{0, 0, 0};
    stream(1'b0, 1'b0);
    check("midrun_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_s_valid", s_valid, 0);
    check("midrun_rst_min_score", min_score, 255);
    check("midrun_rst_r_ready", r_ready, 0);
    sb_score.delete();
    sb_pos.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sv_before = sv_seen;
    repeat (12) @(posedge clk);
    #1;
    check("midrun_no_s_valid", sv_seen, sv_before);
    check("midrun_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
